// File: rtl/adc_capture_ctrl.sv
// ADC acquisition sequencer: settle, decimated capture into a small FIFO,
// and valid/ready delivery downstream with busy/done/overflow status.
module adc_capture_ctrl #(
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 16,
    parameter int DEC_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_125clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_num_samples,
    input  logic [DEC_W-1:0]  i_decim,
    input  logic [7:0]        i_settle,
    output logic              o_adc_en,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic              i_adc_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  num_lat, smp_cnt;
    logic [DEC_W-1:0]  decim_lat, dec_cnt;
    logic [7:0]        settle_cnt;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fill;
    logic              pop, full, sel, push, drop, last_smp, flush, done_nxt;

    assign pop      = o_valid && i_ready;
    assign full     = (fill == (AW+1)'(FIFO_DEPTH));
    assign flush    = (state != S_IDLE) && i_abort;
    assign sel      = (state == S_CAPTURE) && i_adc_valid && (dec_cnt == '0) && !i_abort;
    // A selected word is taken whenever a slot is free or frees up this cycle.
    assign push     = sel && (!full || pop);
    assign drop     = sel && full && !pop;
    assign last_smp = sel && ((smp_cnt + CNT_W'(1)) == num_lat);

    assign o_valid  = (fill != '0);
    assign o_data   = o_valid ? mem[rd_ptr] : '0;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_num_samples == '0) done_nxt  = 1'b1;
                    else                     state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt <= 8'd1) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (last_smp) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if ((fill == '0) || ((fill == (AW+1)'(1)) && pop)) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_125clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= S_IDLE;
            o_busy     <= 1'b0;
            o_adc_en   <= 1'b0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
            num_lat    <= '0;
            decim_lat  <= '0;
            settle_cnt <= '0;
            dec_cnt    <= '0;
            smp_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            o_done   <= done_nxt;
            o_busy   <= (state_nxt != S_IDLE);
            o_adc_en <= (state_nxt == S_SETTLE) || (state_nxt == S_CAPTURE);
            if ((state == S_IDLE) && i_start) begin
                num_lat    <= i_num_samples;
                decim_lat  <= i_decim;
                settle_cnt <= (i_settle == 8'd0) ? 8'd1 : i_settle;
                dec_cnt    <= '0;
                smp_cnt    <= '0;
                o_overflow <= 1'b0;
            end else begin
                if (state == S_SETTLE) settle_cnt <= settle_cnt - 8'd1;
                if ((state == S_CAPTURE) && i_adc_valid)
                    dec_cnt <= (dec_cnt == decim_lat) ? '0 : dec_cnt + DEC_W'(1);
                // Dropped words still consume a slot of the acquisition window.
                if (sel)  smp_cnt    <= smp_cnt + CNT_W'(1);
                if (drop) o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_125clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge i_125clk) begin
        if (push) mem[wr_ptr] <= i_adc_data;
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: queue-based behavioural model compared every
// cycle, directed scenarios with literal expectations, then random acquisitions.
module tb_adc_capture_ctrl;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;
    localparam int DEC_W  = 8;
    localparam int DEPTH  = 4;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_CAPTURE = 2, P_DRAIN = 3;

    logic              i_125clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_start = 1'b0;
    logic              i_abort = 1'b0;
    logic [CNT_W-1:0]  i_num_samples = '0;
    logic [DEC_W-1:0]  i_decim = '0;
    logic [7:0]        i_settle = '0;
    logic              o_adc_en;
    logic [DATA_W-1:0] i_adc_data = '0;
    logic              i_adc_valid = 1'b0;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic              o_busy;
    logic              o_done;
    logic              o_overflow;

    always #4 i_125clk = ~i_125clk;

    adc_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEC_W(DEC_W), .FIFO_DEPTH(DEPTH)) dut (
        .i_125clk(i_125clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_num_samples(i_num_samples), .i_decim(i_decim), .i_settle(i_settle),
        .o_adc_en(o_adc_en), .i_adc_data(i_adc_data), .i_adc_valid(i_adc_valid),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
        .o_done(o_done), .o_overflow(o_overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk1(string nm, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%b required=%b", nm, act, exp);
        end
    endfunction

    function automatic void chk64(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endfunction

    function automatic void chki(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] wd(int n);
        logic [31:0] v;
        v = n;
        return {~v, v};
    endfunction

    // Behavioural model: phase, word index within capture, and a FIFO queue.
    int          m_phase = P_IDLE;
    int          m_left, m_k, m_taken, m_num, m_dec;
    bit          m_done = 1'b0;
    bit          m_ovf = 1'b0;
    logic [63:0] m_q[$];

    always @(posedge i_125clk or negedge i_rst) begin
        if (!i_rst) begin
            m_phase = P_IDLE;
            m_done  = 1'b0;
            m_ovf   = 1'b0;
            m_q.delete();
        end else begin
            bit pop, dn;
            pop = (m_q.size() > 0) && i_ready;
            dn  = 1'b0;
            if (m_phase != P_IDLE && i_abort) begin
                m_phase = P_IDLE;
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                case (m_phase)
                    P_IDLE: if (i_start) begin
                        m_num   = int'(i_num_samples);
                        m_dec   = int'(i_decim);
                        m_left  = (i_settle == 0) ? 1 : int'(i_settle);
                        m_k     = 0;
                        m_taken = 0;
                        m_ovf   = 1'b0;
                        if (m_num == 0) dn = 1'b1;
                        else            m_phase = P_SETTLE;
                    end
                    P_SETTLE: begin
                        m_left--;
                        if (m_left == 0) m_phase = P_CAPTURE;
                    end
                    P_CAPTURE: if (i_adc_valid) begin
                        if (m_k % (m_dec + 1) == 0) begin
                            if (m_q.size() < DEPTH) m_q.push_back(i_adc_data);
                            else                    m_ovf = 1'b1;
                            m_taken++;
                            if (m_taken == m_num) m_phase = P_DRAIN;
                        end
                        m_k++;
                    end
                    default: if (m_q.size() == 0) begin
                        m_phase = P_IDLE;
                        dn      = 1'b1;
                    end
                endcase
            end
            m_done = dn;
        end
    end

    logic [63:0] got[$];
    logic        prev_valid = 1'b0;
    logic [63:0] prev_data = '0;
    int          dut_dones = 0;

    always @(negedge i_125clk) begin
        chk1("busy", o_busy, m_phase != P_IDLE);
        chk1("adc_en", o_adc_en, (m_phase == P_SETTLE) || (m_phase == P_CAPTURE));
        chk1("valid", o_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk64("data", o_data, m_q[0]);
        chk1("done", o_done, m_done);
        chk1("overflow", o_overflow, m_ovf);
        if (prev_valid && i_ready && i_rst) got.push_back(prev_data);
        prev_valid = o_valid;
        prev_data  = o_data;
        if (o_done) dut_dones++;
    end

    int word_id = 0;
    bit rand_mode = 1'b0;

    task automatic tick();
        @(negedge i_125clk);
        #1;
        word_id++;
        i_adc_data = wd(word_id);
        if (rand_mode) begin
            i_adc_valid   = ($urandom_range(0, 9) < 7);
            i_ready       = ($urandom_range(0, 9) < 6);
            i_num_samples = 16'($urandom);
            i_decim       = 8'($urandom);
            i_settle      = 8'($urandom);
        end
    endtask

    task automatic start_acq(int num, int dec, int settle, output int s);
        i_num_samples = 16'(num);
        i_decim       = 8'(dec);
        i_settle      = 8'(settle);
        i_start       = 1'b1;
        s             = word_id;
        tick();
        i_start       = 1'b0;
    endtask

    task automatic wait_idle(int maxc);
        int n;
        n = 0;
        while (o_busy && n < maxc) begin
            tick();
            n++;
        end
        chk1("idle_timeout", o_busy, 1'b0);
    endtask

    task automatic chk_got(string nm, int first, int stride, int n);
        chki({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk64(nm, got[i], wd(first + i * stride));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s, d0;
        i_adc_data = wd(0);
        #3;
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_adc_en", o_adc_en, 1'b0);
        chk1("rst_valid", o_valid, 1'b0);
        chk64("rst_data", o_data, 64'h0);
        chk1("rst_done", o_done, 1'b0);
        chk1("rst_overflow", o_overflow, 1'b0);
        tick(); tick();
        i_rst = 1'b1;
        tick();

        // Basic: no decimation, continuous input, always ready.
        i_adc_valid = 1'b1; i_ready = 1'b1; got.delete(); d0 = dut_dones;
        chk1("basic_en_before", o_adc_en, 1'b0);
        start_acq(4, 0, 2, s);
        chk1("basic_en_after_start", o_adc_en, 1'b1);
        chk1("basic_busy_after_start", o_busy, 1'b1);
        wait_idle(50);
        chk_got("basic", s + 3, 1, 4);
        chki("basic_done_pulses", dut_dones - d0, 1);

        // Decimation keep 1 of 3.
        got.delete();
        start_acq(3, 2, 1, s);
        repeat (7) tick();
        chk1("decim_en_before_last", o_adc_en, 1'b1);
        tick();
        chk1("decim_en_after_last", o_adc_en, 1'b0);
        wait_idle(50);
        chk_got("decim", s + 2, 3, 3);

        // Backpressure: FIFO fills, later words dropped.
        i_ready = 1'b0; got.delete(); d0 = dut_dones;
        start_acq(8, 0, 0, s);
        repeat (12) tick();
        chk1("bp_overflow", o_overflow, 1'b1);
        chk1("bp_valid", o_valid, 1'b1);
        chk1("bp_en_drain", o_adc_en, 1'b0);
        i_ready = 1'b1;
        wait_idle(50);
        chk_got("backpressure", s + 2, 1, 4);
        chki("bp_done_pulses", dut_dones - d0, 1);

        // Push and pop on a full FIFO.
        i_ready = 1'b0; got.delete();
        start_acq(8, 0, 1, s);
        repeat (5) tick();
        chk1("fullpp_valid", o_valid, 1'b1);
        i_ready = 1'b1;
        wait_idle(50);
        chk1("fullpp_overflow", o_overflow, 1'b0);
        chk_got("fullpp", s + 2, 1, 8);

        // Abort after two captured samples.
        i_ready = 1'b0; d0 = dut_dones;
        start_acq(10, 0, 1, s);
        repeat (3) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk1("abort_valid", o_valid, 1'b0);
        chk1("abort_en", o_adc_en, 1'b0);
        chk1("abort_busy", o_busy, 1'b0);
        repeat (3) tick();
        chki("abort_no_done", dut_dones - d0, 0);
        i_ready = 1'b1; got.delete();
        start_acq(2, 0, 1, s);
        wait_idle(50);
        chk_got("after_abort", s + 2, 1, 2);
        chk1("after_abort_ovf", o_overflow, 1'b0);

        // Asynchronous reset while draining.
        i_ready = 1'b0;
        start_acq(4, 0, 1, s);
        repeat (7) tick();
        chk1("drain_valid", o_valid, 1'b1);
        #1;
        i_rst = 1'b0;
        #1;
        chk1("mid_rst_busy", o_busy, 1'b0);
        chk1("mid_rst_adc_en", o_adc_en, 1'b0);
        chk1("mid_rst_valid", o_valid, 1'b0);
        chk64("mid_rst_data", o_data, 64'h0);
        chk1("mid_rst_done", o_done, 1'b0);
        chk1("mid_rst_overflow", o_overflow, 1'b0);
        tick();
        i_rst = 1'b1;
        tick();

        // Start while settling is ignored.
        i_ready = 1'b1; got.delete();
        start_acq(2, 0, 10, s);
        tick(); tick();
        i_num_samples = 16'd7;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_idle(60);
        chk_got("settle_start", s + 11, 1, 2);

        // Zero-sample start.
        d0 = dut_dones;
        i_num_samples = 16'd0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk1("zero_done", o_done, 1'b1);
        chk1("zero_en", o_adc_en, 1'b0);
        chk1("zero_busy", o_busy, 1'b0);
        tick();
        chk1("zero_done_once", o_done, 1'b0);
        chk1("zero_en_later", o_adc_en, 1'b0);

        // Random acquisitions with noise on start/abort/config.
        rand_mode = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int n;
            i_abort = ($urandom_range(0, 3) == 0);
            start_acq($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 5), s);
            i_abort = 1'b0;
            n = 0;
            while (o_busy && n < 400) begin
                i_abort = ($urandom_range(0, 99) == 0);
                i_start = ($urandom_range(0, 29) == 0);
                tick();
                n++;
            end
            i_abort = 1'b0;
            i_start = 1'b0;
            chk1("rand_idle_timeout", o_busy, 1'b0);
            repeat ($urandom_range(0, 3)) begin
                i_abort = $urandom_range(0, 1) == 1;
                tick();
            end
            i_abort = 1'b0;
        end
        rand_mode = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Acquisition sequencer for the 64-bit ADC word stream produced in the 125 MHz domain. On a start command it enables the ADC and waits a programmable settle time. It then captures a programmed number of decimated samples into a 4-entry output FIFO and presents them downstream on a valid/ready handshake. It sits between the ADC front-end block and the sample consumer, and reports busy, done and overflow status to the host/control logic.

## Interface
- DATA_W, 64, ADC word width
- CNT_W, 16, width of the sample-count configuration
- DEC_W, 8, width of the decimation configuration
- FIFO_DEPTH, 4, output FIFO entries (power of two)

- i_125clk  in  1  system clock, 125 MHz, all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_start  in  1  start pulse; honoured only in IDLE
- i_abort  in  1  abort; honoured in any non-IDLE state
- i_num_samples  in  CNT_W  samples to deliver per acquisition
- i_decim  in  DEC_W  keep 1 of every i_decim+1 ADC words
- i_settle  in  8  settle cycles after ADC enable
- o_adc_en  out  1  ADC front-end enable
- i_adc_data  in  DATA_W  ADC word
- i_adc_valid  in  1  i_adc_data valid this cycle
- o_data  out  DATA_W  FIFO head word
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts o_data
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse at normal completion
- o_overflow  out  1  sticky; sample dropped because FIFO full

## Operation
- States: IDLE, SETTLE, CAPTURE, DRAIN.
- IDLE: o_adc_en=0. When i_start=1:
  - i_num_samples, i_decim and i_settle are latched; later changes are ignored until the next start.
  - o_overflow is cleared and the sample/decimation counters are zeroed.
  - If i_num_samples=0, stay in IDLE and pulse o_done the next cycle.
  - Otherwise go to SETTLE.
- SETTLE: o_adc_en=1. Lasts max(i_settle,1) cycles. ADC words arriving in this state are discarded. Then go to CAPTURE.
- CAPTURE: o_adc_en=1.
  - Each i_adc_valid word advances the decimation counter.
  - A word is selected when the counter equals 0. The counter then runs 0..i_decim and wraps, so the first valid word after SETTLE is always selected.
  - A selected word is pushed to the FIFO and increments the sample count.
  - If the FIFO is full and no pop happens that cycle, the word is dropped, o_overflow is set, and the word still counts. The acquisition window is fixed in samples.
  - When the count reaches the latched i_num_samples, go to DRAIN.
- DRAIN: o_adc_en=0. When the FIFO is empty, go to IDLE and pulse o_done.
- Abort (non-IDLE): next cycle state=IDLE, FIFO flushed (o_valid=0), o_adc_en=0, no o_done. o_overflow is retained.
- i_start while busy is ignored. i_abort in IDLE is ignored. If i_start and i_abort are both high in IDLE, start wins.
- FIFO rules:
  - A pop occurs on o_valid&&i_ready.
  - Push and pop in the same cycle are legal at any fill level, including full; the push is accepted.
  - o_data is stable while o_valid=1 and i_ready=0.

## Timing
- Reset (i_rst=0): state=IDLE, all counters 0, FIFO empty. All outputs are 0: o_adc_en, o_data, o_valid, o_busy, o_done, o_overflow.
- i_start sampled high at edge N: o_busy=1 and o_adc_en=1 from N+1.
- For i_settle=S, CAPTURE begins at edge N+1+max(S,1).
- Push latency: a selected word at edge M appears on o_data with o_valid=1 from M+1 if the FIFO was empty. There is no combinational path from i_adc_* to o_*.
- Count reached at edge M: o_adc_en=0 from M+1.
- Completion: the cycle after the final pop, state=IDLE and o_done=1 for exactly one cycle.
- Abort at edge A: o_busy=0, o_adc_en=0 and o_valid=0 from A+1.
- Reset mid-acquisition: outputs clear immediately (asynchronous assert). Release is synchronous to i_125clk.

## Test plan
- Basic: num=4, decim=0, settle=2, adc_valid every cycle, i_ready=1 -> adc_en high 1 cycle after start. Four consecutive words delivered, the first being the word presented 3 cycles after start. Then o_done single pulse, o_busy=0.
- Decimation: num=3, decim=2, words 0..20 sequential -> delivered words are 0,3,6 relative to CAPTURE start. adc_en drops after the 7th valid word.
- Backpressure: num=8, decim=0, i_ready=0 throughout CAPTURE -> exactly 4 words buffered and o_overflow=1. With i_ready raised, the first 4 words drain in order, then o_done pulses.
- Full push/pop: FIFO full, push and pop in the same cycle -> no overflow, occupancy stays 4, order preserved.
- Abort mid-CAPTURE after 2 of 10 samples -> next cycle o_valid=0, o_adc_en=0, o_busy=0, no o_done. A following start runs normally with o_overflow cleared.
- Reset asserted during DRAIN; i_start during SETTLE; num=0 start -> all outputs 0 immediately on reset; start during SETTLE has no effect; num=0 start gives o_done one cycle later and o_adc_en never rises.
